inst_loader: RTL and testbench

- Byte-stream program loader: the writer side of the processor's 64-word instruction memory.
- Receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Issues one-cycle write strobes into instruction memory and holds the processor in reset until the load completes with a good checksum.
- Sits between the board serial/byte receiver and the InstMem write port.

---
 rtl/inst_loader.sv | 160 ++++++++++++++++
 tb/tb_inst_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Program loader: framed byte stream (N, 4*N LE data bytes, XOR checksum) into instruction memory.
// Latency: write strobe one cycle after the byte completing a word; done/err/cpu_hold registered.
// Backpressure: in_ready high in IDLE/DATA/CHECK (writes never stall), low in DONE/ERR until reload.
module inst_loader #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int WL_W  = ADDR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int MAX_N = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state;
  logic [WL_W-1:0] n_words;
  logic [1:0]      byte_idx;
  logic [23:0]     asm_word;
  logic [7:0]      csum;
  logic [TO_W-1:0] tout_cnt;

  logic accept;
  logic hdr_bad;
  logic last_word;
  logic tout_hit;

  assign accept    = in_valid & in_ready;
  assign hdr_bad   = (in_data == 8'd0) || ({24'd0, in_data} > 32'(MAX_N));
  assign last_word = (words_loaded + WL_W'(1)) == n_words;
  // Counter equal to TIMEOUT-1 on an idle cycle means this edge is the TIMEOUT-th idle cycle.
  assign tout_hit  = tout_cnt == TO_W'(TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      in_ready     <= 1'b1;
      cpu_hold     <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      n_words      <= '0;
      byte_idx     <= '0;
      asm_word     <= '0;
      csum         <= '0;
      tout_cnt     <= '0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            if (hdr_bad) begin
              state    <= S_ERR;
              in_ready <= 1'b0;
              err      <= 1'b1;
            end else begin
              state        <= S_DATA;
              n_words      <= WL_W'(in_data);
              csum         <= '0;
              byte_idx     <= '0;
              words_loaded <= '0;
              tout_cnt     <= '0;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            tout_cnt <= '0;
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            unique case (byte_idx)
              2'd0: asm_word[7:0]   <= in_data;
              2'd1: asm_word[15:8]  <= in_data;
              2'd2: asm_word[23:16] <= in_data;
              2'd3: begin
                // Lane 3 goes straight into the write data, so no fourth assembly byte is stored.
                mem_we       <= 1'b1;
                mem_addr     <= words_loaded[ADDR_W-1:0];
                mem_wdata    <= {in_data, asm_word};
                words_loaded <= words_loaded + WL_W'(1);
                if (last_word) state <= S_CHECK;
              end
              default: ;
            endcase
          end else if (tout_hit) begin
            state    <= S_ERR;
            in_ready <= 1'b0;
            err      <= 1'b1;
          end else begin
            tout_cnt <= tout_cnt + TO_W'(1);
          end
        end

        S_CHECK: begin
          if (accept) begin
            tout_cnt <= '0;
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end else if (tout_hit) begin
            state    <= S_ERR;
            in_ready <= 1'b0;
            err      <= 1'b1;
          end else begin
            tout_cnt <= tout_cnt + TO_W'(1);
          end
        end

        S_DONE, S_ERR: begin
          if (reload) begin
            state        <= S_IDLE;
            in_ready     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            cpu_hold     <= 1'b1;
            words_loaded <= '0;
          end
        end

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
          cpu_hold <= 1'b1;
          done     <= 1'b0;
          err      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: random frames against a byte/word-level frame model and a write log.
module tb_inst_loader;

  localparam int ADDR_W  = 6;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              reload;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  inst_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc;
  int stall_cnt;

  logic [31:0] frame_words[$];
  int          lane3_edge[$];
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  logic [31:0] mem_model[64];

  always @(posedge clk) cyc <= cyc + 1;

  // Write log: the strobe launched at edge e is seen at the negedge where cyc == e.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(mem_wdata);
      wr_cyc_q.push_back(cyc);
      mem_model[mem_addr] = mem_wdata;
    end
  end

  function automatic logic [7:0] model_csum();
    logic [7:0] c = 8'h00;
    foreach (frame_words[k]) begin
      logic [31:0] w;
      w = frame_words[k];
      c = c ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    end
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    int w = 0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (w > 0) stall_cnt++;
    total++;
    if (in_ready !== 1'b1) begin
      $display("FAIL send_byte_ready: in_ready=%b required 1 within 40 cycles", in_ready);
      bad++;
    end
    last_acc = cyc + 1;
    @(posedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] hdr, input logic [7:0] ck, input int max_gap,
                             input bit send_ck);
    lane3_edge.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    stall_cnt = 0;
    send_byte(hdr, $urandom_range(0, max_gap));
    foreach (frame_words[k]) begin
      logic [31:0] w;
      w = frame_words[k];
      for (int j = 0; j < 4; j++) begin
        send_byte(w[8*j +: 8], $urandom_range(0, max_gap));
        if (j == 3) lane3_edge.push_back(last_acc);
      end
    end
    if (send_ck) send_byte(ck, $urandom_range(0, max_gap));
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
    repeat (3) @(negedge clk);
    total += 8;
    if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b want 1", in_ready); bad++; end
    if (cpu_hold !== 1'b1) begin $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); bad++; end
    if (mem_we !== 1'b0) begin $display("FAIL reset_mem_we: got %b want 0", mem_we); bad++; end
    if (mem_addr !== '0) begin $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); bad++; end
    if (mem_wdata !== '0) begin $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); bad++; end
    if (done !== 1'b0) begin $display("FAIL reset_done: got %b want 0", done); bad++; end
    if (err !== 1'b0) begin $display("FAIL reset_err: got %b want 0", err); bad++; end
    if (words_loaded !== '0) begin $display("FAIL reset_words: got %0d want 0", words_loaded); bad++; end
    rst = 1'b1;
  endtask

  // Checks of a completed frame against the model: write log then final status.
  task automatic test_frame(input string name, input int max_gap, input bit good);
    int n;
    logic [7:0] ck;
    n  = frame_words.size();
    ck = good ? model_csum() : (model_csum() ^ 8'($urandom_range(1, 255)));
    do_reload();
    drive_frame(8'(n), ck, max_gap, 1'b1);
    total++;
    if (wr_addr_q.size() != n) begin
      $display("FAIL %s_wr_count: got %0d want %0d", name, wr_addr_q.size(), n); bad++;
    end else begin
      for (int k = 0; k < n; k++) begin
        total += 3;
        if (wr_addr_q[k] != k) begin $display("FAIL %s_addr[%0d]: got %0d want %0d", name, k, wr_addr_q[k], k); bad++; end
        if (wr_data_q[k] !== frame_words[k]) begin $display("FAIL %s_data[%0d]: got %h want %h", name, k, wr_data_q[k], frame_words[k]); bad++; end
        if (wr_cyc_q[k] != lane3_edge[k]) begin $display("FAIL %s_wr_cycle[%0d]: got %0d want %0d", name, k, wr_cyc_q[k], lane3_edge[k]); bad++; end
      end
    end
    total += 5;
    if (done !== good) begin $display("FAIL %s_done: got %b want %b", name, done, good); bad++; end
    if (err !== !good) begin $display("FAIL %s_err: got %b want %b", name, err, !good); bad++; end
    if (cpu_hold !== !good) begin $display("FAIL %s_cpu_hold: got %b want %b", name, cpu_hold, !good); bad++; end
    if (in_ready !== 1'b0) begin $display("FAIL %s_in_ready: got %b want 0", name, in_ready); bad++; end
    if (words_loaded != n) begin $display("FAIL %s_words_loaded: got %0d want %0d", name, words_loaded, n); bad++; end
  endtask

  task automatic test_single_word();
    frame_words = '{32'h0000_0013};
    test_frame("single", 0, 1'b1);
    total += 2;
    if (mem_addr !== 6'd0 || mem_wdata !== 32'h13) begin
      $display("FAIL single_hold: got addr %0d data %h want 0 00000013", mem_addr, mem_wdata); bad++;
    end
    if (mem_we !== 1'b0) begin $display("FAIL single_we_idle: got %b want 0", mem_we); bad++; end
  endtask

  task automatic test_back_to_back();
    frame_words = '{32'h0050_0093, 32'h0010_0113};
    test_frame("b2b", 0, 1'b1);
    total++;
    if (stall_cnt != 0) begin $display("FAIL b2b_stall: got %0d stalls want 0", stall_cnt); bad++; end
  endtask

  task automatic test_bad_checksum();
    frame_words = '{32'h0050_0093, 32'h0010_0113};
    test_frame("badck", 0, 1'b0);
    do_reload();
    total += 5;
    if (err !== 1'b0) begin $display("FAIL reload_err: got %b want 0", err); bad++; end
    if (done !== 1'b0) begin $display("FAIL reload_done: got %b want 0", done); bad++; end
    if (cpu_hold !== 1'b1) begin $display("FAIL reload_cpu_hold: got %b want 1", cpu_hold); bad++; end
    if (in_ready !== 1'b1) begin $display("FAIL reload_in_ready: got %b want 1", in_ready); bad++; end
    if (words_loaded !== '0) begin $display("FAIL reload_words: got %0d want 0", words_loaded); bad++; end
  endtask

  task automatic test_header_bounds();
    logic [7:0] hdrs [2];
    hdrs[0] = 8'd0;
    hdrs[1] = 8'd65;
    for (int h = 0; h < 2; h++) begin
      do_reload();
      frame_words.delete();
      drive_frame(hdrs[h], 8'h00, 0, 1'b0);
      total += 2;
      if (err !== 1'b1) begin $display("FAIL hdr%0d_err: got %b want 1", hdrs[h], err); bad++; end
      if (wr_addr_q.size() != 0) begin $display("FAIL hdr%0d_writes: got %0d want 0", hdrs[h], wr_addr_q.size()); bad++; end
    end
    do_reload();
    frame_words.delete();
    for (int k = 0; k < 64; k++) frame_words.push_back($urandom);
    drive_frame(8'd64, 8'h00, 1, 1'b0);
    total += 4;
    if (wr_addr_q.size() != 64) begin
      $display("FAIL n64_wr_count: got %0d want 64", wr_addr_q.size()); bad++;
    end else begin
      for (int k = 0; k < 64; k++) begin
        if (wr_addr_q[k] != k || wr_data_q[k] !== frame_words[k]) begin
          $display("FAIL n64_write[%0d]: got %0d/%h want %0d/%h", k, wr_addr_q[k], wr_data_q[k], k, frame_words[k]);
          bad++;
        end
      end
    end
    if (in_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      $display("FAIL n64_check_state: got ready=%b done=%b err=%b want 1 0 0", in_ready, done, err); bad++;
    end
    if (words_loaded != 64) begin $display("FAIL n64_words: got %0d want 64", words_loaded); bad++; end
    send_byte(model_csum(), 0);
    @(negedge clk);
    in_valid = 1'b0;
    if (done !== 1'b1) begin $display("FAIL n64_done: got %b want 1", done); bad++; end
  endtask

  task automatic test_timeout();
    int first_err = -1;
    do_reload();
    wr_addr_q.delete();
    send_byte(8'd1, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 2);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 40 && first_err < 0; i++) begin
      @(negedge clk);
      if (err === 1'b1) first_err = cyc;
    end
    total += 2;
    if (first_err != last_acc + TIMEOUT) begin
      $display("FAIL timeout_cycle: got err at %0d cycles want %0d", first_err - last_acc, TIMEOUT); bad++;
    end
    if (wr_addr_q.size() != 0) begin $display("FAIL timeout_writes: got %0d want 0", wr_addr_q.size()); bad++; end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] old_w;
    do_reload();
    wr_addr_q.delete();
    old_w = $urandom;
    send_byte(8'd2, 0);
    for (int j = 0; j < 4; j++) send_byte(old_w[8*j +: 8], 0);
    for (int j = 0; j < 3; j++) send_byte(8'($urandom), 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    total += 4;
    if (mem_model[0] !== old_w) begin $display("FAIL mid_first_word: got %h want %h", mem_model[0], old_w); bad++; end
    if (in_ready !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      $display("FAIL mid_rst_flags: got ready=%b hold=%b done=%b err=%b want 1 1 0 0", in_ready, cpu_hold, done, err); bad++;
    end
    if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      $display("FAIL mid_rst_mem: got we=%b addr=%0d data=%h want 0 0 0", mem_we, mem_addr, mem_wdata); bad++;
    end
    if (words_loaded !== '0) begin $display("FAIL mid_rst_words: got %0d want 0", words_loaded); bad++; end
    frame_words = '{~old_w};
    test_frame("mid_new", 2, 1'b1);
    total++;
    if (mem_model[0] !== ~old_w) begin $display("FAIL mid_overwrite: got %h want %h", mem_model[0], ~old_w); bad++; end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int n;
      n = $urandom_range(1, 8);
      frame_words.delete();
      for (int k = 0; k < n; k++) frame_words.push_back($urandom);
      test_frame($sformatf("rand%0d", f), 3, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_bad_checksum();
    test_header_bounds();
    test_timeout();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
